fake_signal_checker: RTL and testbench

Receive-side companion to the fake-signal injector: monitors one packed ADC stream (HG in [23:12], LG in [11:0]) downstream of the injection point and validates each synthetic pulse. It detects pulse start and end against a pedestal threshold, checks the HG ramp and the HG/LG consistency, and measures width, peak and start-to-start interval. Results go to software-readable counters and status registers.

---
 rtl/fake_signal_checker_if.sv | 26 ++
 rtl/fake_signal_checker.sv | 194 +++++++++++++++++++
 tb/tb_fake_signal_checker.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fake_signal_checker_if.sv
// Bundles the ADC stream, control inputs and result registers of fake_signal_checker.
// No handshake: every clock carries one valid ADC word and the checker never stalls.
interface fake_signal_checker_if;
    logic        i_enable;
    logic        i_clear;
    logic [23:0] i_adc_in;
    logic        o_pulse_done;
    logic [15:0] o_pulse_count;
    logic [15:0] o_err_count;
    logic        o_err_flag;
    logic [15:0] o_last_width;
    logic [11:0] o_last_peak;
    logic [31:0] o_last_interval;

    modport master (
        output i_enable, i_clear, i_adc_in,
        input  o_pulse_done, o_pulse_count, o_err_count, o_err_flag,
               o_last_width, o_last_peak, o_last_interval
    );

    modport slave (
        input  i_enable, i_clear, i_adc_in,
        output o_pulse_done, o_pulse_count, o_err_count, o_err_flag,
               o_last_width, o_last_peak, o_last_interval
    );
endinterface

// File: rtl/fake_signal_checker.sv
// Validates and measures synthetic pulses on a packed {HG, LG} ADC stream.
// Define FAKE_CHECK_LG_EN to compile in the LG-versus-HG consistency check.
module fake_signal_checker #(
    parameter int PEDESTAL  = 200,
    parameter int THRESHOLD = 20,
    parameter int LG_SHIFT  = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fake_signal_checker_if.slave io_bus,
    output logic                 o_dbg_state
);

    localparam logic [11:0] LP_TRIP  = 12'(PEDESTAL + THRESHOLD);
    localparam logic [12:0] LP_PED13 = 13'(PEDESTAL);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_IN_PULSE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_start;
    logic        w_cont;
    logic        w_end;

    logic [11:0] r_hg;
    logic [11:0] r_lg;
    logic        w_above;
    logic        w_lg_err;
    logic        w_ramp_err;

    logic [15:0] r_width;
    logic [11:0] r_peak;
    logic [11:0] r_prev;
    logic        r_pulse_err;
    logic [31:0] r_int_cnt;
    logic [31:0] r_int_capture;

    logic        r_pulse_done;
    logic [15:0] r_pulse_count;
    logic [15:0] r_err_count;
    logic        r_err_flag;
    logic [15:0] r_last_width;
    logic [11:0] r_last_peak;
    logic [31:0] r_last_interval;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hg <= 12'd0;
            r_lg <= 12'd0;
        end else begin
            r_hg <= io_bus.i_adc_in[23:12];
            r_lg <= io_bus.i_adc_in[11:0];
        end
    end

    assign w_above    = (r_hg > LP_TRIP);
    // 13-bit compare so that a predecessor of 0xFFF can never be followed legally.
    assign w_ramp_err = ({1'b0, r_hg} != ({1'b0, r_prev} + 13'd1));

`ifdef FAKE_CHECK_LG_EN
    logic signed [12:0] w_hg_excess;
    logic        [12:0] w_lg_expect;
    assign w_hg_excess = $signed({1'b0, r_hg}) - $signed(LP_PED13);
    assign w_lg_expect = $unsigned(w_hg_excess >>> LG_SHIFT) + LP_PED13;
    assign w_lg_err    = w_hg_excess[12] || (w_lg_expect != {1'b0, r_lg});
`else
    logic w_unused_lg;
    assign w_unused_lg = ^r_lg;
    assign w_lg_err    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_cont       = 1'b0;
        w_end        = 1'b0;
        if (!io_bus.i_enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_above) begin
                        w_next_state = S_IN_PULSE;
                        w_start      = 1'b1;
                    end
                end
                S_IN_PULSE: begin
                    if (w_above) begin
                        w_cont = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                        w_end        = 1'b1;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    assign o_dbg_state = (r_state == S_IN_PULSE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_width       <= 16'd0;
            r_peak        <= 12'd0;
            r_prev        <= 12'd0;
            r_pulse_err   <= 1'b0;
            r_int_capture <= 32'd0;
        end else if (w_start) begin
            r_width       <= 16'd1;
            r_peak        <= r_hg;
            r_prev        <= r_hg;
            r_pulse_err   <= w_lg_err;
            r_int_capture <= r_int_cnt;
        end else if (w_cont) begin
            if (r_width != 16'hFFFF) begin
                r_width <= r_width + 16'd1;
            end
            if (r_hg > r_peak) begin
                r_peak <= r_hg;
            end
            r_prev      <= r_hg;
            r_pulse_err <= r_pulse_err | w_ramp_err | w_lg_err;
        end
    end

    // Free-running start-to-start timer; ENABLE does not gate it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_int_cnt <= 32'd0;
        end else if (w_start) begin
            r_int_cnt <= 32'd1;
        end else if (r_int_cnt != 32'hFFFF_FFFF) begin
            r_int_cnt <= r_int_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pulse_done    <= 1'b0;
            r_pulse_count   <= 16'd0;
            r_err_count     <= 16'd0;
            r_err_flag      <= 1'b0;
            r_last_width    <= 16'd0;
            r_last_peak     <= 12'd0;
            r_last_interval <= 32'd0;
        end else begin
            r_pulse_done <= w_end;
            if (w_end) begin
                r_last_width    <= r_width;
                r_last_peak     <= r_peak;
                r_last_interval <= r_int_capture;
                if (r_pulse_count != 16'hFFFF) begin
                    r_pulse_count <= r_pulse_count + 16'd1;
                end
                if (r_pulse_err) begin
                    r_err_flag <= 1'b1;
                    if (r_err_count != 16'hFFFF) begin
                        r_err_count <= r_err_count + 16'd1;
                    end
                end
            end
            // Clear overrides a coinciding pulse end, but the strobe above still fires.
            if (io_bus.i_clear) begin
                r_pulse_count   <= 16'd0;
                r_err_count     <= 16'd0;
                r_err_flag      <= 1'b0;
                r_last_width    <= 16'd0;
                r_last_peak     <= 12'd0;
                r_last_interval <= 32'd0;
            end
        end
    end

    assign io_bus.o_pulse_done    = r_pulse_done;
    assign io_bus.o_pulse_count   = r_pulse_count;
    assign io_bus.o_err_count     = r_err_count;
    assign io_bus.o_err_flag      = r_err_flag;
    assign io_bus.o_last_width    = r_last_width;
    assign io_bus.o_last_peak     = r_last_peak;
    assign io_bus.o_last_interval = r_last_interval;

endmodule

// File: tb/tb_fake_signal_checker.sv
// Bench for fake_signal_checker: directed test-plan scenarios plus randomized pulses
// compared every cycle against a pulse-level reference model.
module tb_fake_signal_checker;

    localparam int PED  = 200;
    localparam int TRIP = 220;
`ifdef FAKE_CHECK_LG_EN
    localparam int LG_SHIFT = 5;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    fake_signal_checker_if bus();
    logic dbg_state;

    fake_signal_checker dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .io_bus      (bus),
        .o_dbg_state (dbg_state)
    );

    int n_checks   = 0;
    int n_bad      = 0;
    int n_done_obs = 0;
    logic [15:0] exp_q[$];

    logic [23:0] m_pulse[$];
    logic [23:0] m_reg;
    bit          m_in_pulse;
    longint      m_edge;
    longint      m_reset_edge;
    longint      m_last_start;
    logic [31:0] m_cap;
    bit          m_done;
    logic [15:0] m_count;
    logic [15:0] m_errc;
    bit          m_flag;
    logic [15:0] m_width;
    logic [11:0] m_peak;
    logic [31:0] m_last_int;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] lg_of(input int hg);
        return 12'(((hg - PED) >> 5) + PED);
    endfunction

    function automatic bit pulse_errored();
        bit err = 1'b0;
        for (int i = 0; i < m_pulse.size(); i++) begin
            int hg = int'(m_pulse[i][23:12]);
`ifdef FAKE_CHECK_LG_EN
            int lg = int'(m_pulse[i][11:0]);
            if (hg < PED || lg != ((hg - PED) >> LG_SHIFT) + PED) err = 1'b1;
`endif
            if (i > 0 && hg != int'(m_pulse[i-1][23:12]) + 1) err = 1'b1;
        end
        return err;
    endfunction

    task automatic model_edge(input bit rst, input bit en, input bit clr, input logic [23:0] adc);
        int hg;
        m_edge++;
        m_done = 1'b0;
        if (!rst) begin
            m_in_pulse = 1'b0;
            m_pulse.delete();
            m_reset_edge = m_edge;
            m_last_start = -1;
            m_count = 0; m_errc = 0; m_flag = 0; m_width = 0; m_peak = 0; m_last_int = 0;
            m_reg = 24'd0;
            return;
        end
        hg = int'(m_reg[23:12]);
        if (!en) begin
            m_in_pulse = 1'b0;
            m_pulse.delete();
        end else if (!m_in_pulse) begin
            if (hg > TRIP) begin
                longint gap;
                m_in_pulse = 1'b1;
                m_pulse.delete();
                m_pulse.push_back(m_reg);
                gap = (m_last_start < 0) ? (m_edge - m_reset_edge - 1) : (m_edge - m_last_start);
                m_cap = (gap > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(gap);
                m_last_start = m_edge;
            end
        end else if (hg > TRIP) begin
            m_pulse.push_back(m_reg);
        end else begin
            int pk = 0;
            m_in_pulse = 1'b0;
            m_done = 1'b1;
            foreach (m_pulse[i]) if (int'(m_pulse[i][23:12]) > pk) pk = int'(m_pulse[i][23:12]);
            m_width    = (m_pulse.size() > 65535) ? 16'hFFFF : 16'(m_pulse.size());
            m_peak     = 12'(pk);
            m_last_int = m_cap;
            if (m_count != 16'hFFFF) m_count++;
            if (pulse_errored()) begin
                m_flag = 1'b1;
                if (m_errc != 16'hFFFF) m_errc++;
            end
            m_pulse.delete();
        end
        if (clr) begin
            m_count = 0; m_errc = 0; m_flag = 0; m_width = 0; m_peak = 0; m_last_int = 0;
        end
        if (m_done) exp_q.push_back(m_width);
        m_reg = adc;
    endtask

    task automatic compare_all();
        check_val("done",     bus.o_pulse_done,    m_done);
        check_val("count",    bus.o_pulse_count,   m_count);
        check_val("errc",     bus.o_err_count,     m_errc);
        check_val("flag",     bus.o_err_flag,      m_flag);
        check_val("width",    bus.o_last_width,    m_width);
        check_val("peak",     bus.o_last_peak,     m_peak);
        check_val("interval", bus.o_last_interval, m_last_int);
        check_val("state",    dbg_state,           m_in_pulse);
        if (bus.o_pulse_done) begin
            n_done_obs++;
            if (exp_q.size() == 0) check_val("sb_extra_done", bus.o_pulse_done, 1'b0);
            else                   check_val("sb_width", bus.o_last_width, exp_q.pop_front());
        end
    endtask

    task automatic step(input logic [11:0] hg, input logic [11:0] lg,
                        input bit en = 1'b1, input bit clr = 1'b0, input bit rst = 1'b1);
        bus.i_adc_in = {hg, lg};
        bus.i_enable = en;
        bus.i_clear  = clr;
        rst_n        = rst;
        @(posedge clk);
        model_edge(rst, en, clr, {hg, lg});
        #1;
        compare_all();
    endtask

    task automatic baseline(input int n);
        for (int i = 0; i < n; i++) step(12'(PED), 12'(PED));
    endtask

    task automatic ramp(input bit skip251, input bit lg_flat, input bit drop_en, input bit rst_mid);
        bit en = 1'b1;
        for (int v = 200; v < 300; v++) begin
            if (skip251 && v == 251) continue;
            if (drop_en && v >= 250) en = 1'b0;
            if (rst_mid && v == 250) begin
                step(12'(v), lg_of(v), 1'b1, 1'b0, 1'b0);
                return;
            end
            step(12'(v), lg_flat ? 12'(PED) : lg_of(v), en);
        end
    endtask

    task automatic random_pulse();
        int gap  = $urandom_range(1, 6);
        int hg   = $urandom_range(221, 4000);
        int len  = $urandom_range(1, 40);
        for (int i = 0; i < gap; i++)
            step(12'($urandom_range(0, TRIP)), 12'($urandom_range(0, 4095)),
                 $urandom_range(0, 59) != 0, $urandom_range(0, 49) == 0);
        for (int i = 0; i < len; i++) begin
            logic [11:0] lg = lg_of(hg);
            if ($urandom_range(0, 9) == 0) lg = 12'($urandom_range(0, 4095));
            step(12'(hg), lg, $urandom_range(0, 59) != 0, $urandom_range(0, 49) == 0);
            hg = hg + 1 + (($urandom_range(0, 11) == 0) ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 15) == 0) hg = hg - 1;
            if (hg > 4095) hg = 4095;
        end
    endtask

    initial begin
        int d0;
        bus.i_adc_in = 24'd0;
        bus.i_enable = 1'b0;
        bus.i_clear  = 1'b0;
        m_edge = 0; m_reset_edge = 0; m_last_start = -1; m_reg = 0; m_cap = 0;
        m_in_pulse = 0; m_done = 0; m_count = 0; m_errc = 0; m_flag = 0;
        m_width = 0; m_peak = 0; m_last_int = 0;

        for (int i = 0; i < 3; i++) step(12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        check_val("rst_count", bus.o_pulse_count, 0);
        check_val("rst_done",  bus.o_pulse_done, 0);
        check_val("rst_int",   bus.o_last_interval, 0);
        baseline(10);

        // Clean ramp
        d0 = n_done_obs;
        ramp(0, 0, 0, 0); baseline(4);
        check_val("clean_dones", n_done_obs - d0, 1);
        check_val("clean_count", bus.o_pulse_count, 1);
        check_val("clean_width", bus.o_last_width, 79);
        check_val("clean_peak",  bus.o_last_peak, 299);
        check_val("clean_errc",  bus.o_err_count, 0);
        check_val("clean_flag",  bus.o_err_flag, 0);

        // Ramp with a 250->252 jump
        step(12'(PED), 12'(PED), 1'b1, 1'b1);
        ramp(1, 0, 0, 0); baseline(4);
        check_val("jump_count", bus.o_pulse_count, 1);
        check_val("jump_errc",  bus.o_err_count, 1);
        check_val("jump_flag",  bus.o_err_flag, 1);
        check_val("jump_width", bus.o_last_width, 78);

        // LG held at pedestal
        step(12'(PED), 12'(PED), 1'b1, 1'b1);
        ramp(0, 1, 0, 0); baseline(4);
`ifdef FAKE_CHECK_LG_EN
        check_val("lgflat_errc", bus.o_err_count, 1);
`else
        check_val("lgflat_errc", bus.o_err_count, 0);
`endif

        // Two pulses starting 1000 cycles apart
        step(12'(PED), 12'(PED), 1'b1, 1'b1);
        ramp(0, 0, 0, 0); baseline(900);
        ramp(0, 0, 0, 0); baseline(4);
        check_val("intv_value", bus.o_last_interval, 1000);
        check_val("intv_count", bus.o_pulse_count, 2);

        // ENABLE dropped mid-pulse
        d0 = n_done_obs;
        ramp(0, 0, 1, 0);
        step(12'(PED), 12'(PED), 1'b0); step(12'(PED), 12'(PED), 1'b0);
        baseline(4);
        check_val("endrop_dones", n_done_obs - d0, 0);
        check_val("endrop_count", bus.o_pulse_count, 2);

        // Reset mid-pulse, then a clean pulse
        ramp(0, 0, 0, 1);
        check_val("rstmid_count", bus.o_pulse_count, 0);
        check_val("rstmid_width", bus.o_last_width, 0);
        check_val("rstmid_state", dbg_state, 0);
        baseline(5);
        ramp(0, 0, 0, 0); baseline(4);
        check_val("rstmid_next_count", bus.o_pulse_count, 1);
        check_val("rstmid_next_width", bus.o_last_width, 79);

        // Width-1 pulse
        step(12'd221, 12'(PED)); baseline(3);
        check_val("w1_width", bus.o_last_width, 1);
        check_val("w1_peak",  bus.o_last_peak, 221);

        // CLEAR on the cycle the terminating sample is acted on
        ramp(1, 0, 0, 0);
        step(12'(PED), 12'(PED));
        step(12'(PED), 12'(PED), 1'b1, 1'b1);
        check_val("clrend_done",  bus.o_pulse_done, 1);
        check_val("clrend_count", bus.o_pulse_count, 0);
        check_val("clrend_flag",  bus.o_err_flag, 0);
        check_val("clrend_width", bus.o_last_width, 0);
        baseline(3);

        for (int i = 0; i < 60; i++) random_pulse();
        baseline(4);
        check_val("sb_leftover", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
